// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, fetch FSM states and prefetch entry type for the fetch front end
package proc_pkg;
    localparam int ADDR_W = 8;
    localparam int INSTR_W = 16;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory, control-unit and redirect signals of the fetch stage
interface instruction_fetch_unit_if;
    import proc_pkg::*;
    logic fetch_en;
    logic imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic instr_ready;
    logic redirect_en;
    logic [ADDR_W-1:0] redirect_pc;
    modport master (
        input fetch_en, imem_ack, imem_rdata, instr_ready, redirect_en, redirect_pc,
        output imem_req, imem_addr, instr_valid, instr_data, instr_pc
    );
    modport slave (
        output fetch_en, imem_ack, imem_rdata, instr_ready, redirect_en, redirect_pc,
        input imem_req, imem_addr, instr_valid, instr_data, instr_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry prefetch FIFO with flush; head is read straight from registered storage
module fetch_fifo
    import proc_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic reset,
    input logic push,
    input logic pop,
    input logic flush,
    input fetch_entry_t wr_entry,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction
    always_comb begin
        mem_d = mem_q;
        rd_d = flush ? '0 : pop ? nxt(rd_q) : rd_q;
        wr_d = flush ? '0 : push ? nxt(wr_q) : wr_q;
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
        if (push && !flush) mem_d[wr_q] = wr_entry;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
            rd_q <= '0;
            wr_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            count_q <= count_d;
        end
    end
    assign count = count_q;
    assign head = mem_q[rd_q];
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner issuing single-outstanding imem requests into a prefetch FIFO
module instruction_fetch_unit
    import proc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic reset,
    instruction_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    fetch_state_t state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic push, pop;
    logic [CW-1:0] count;
    logic [CW:0] post_cnt;
    fetch_entry_t head;
    assign pop = bus.instr_valid && bus.instr_ready && !bus.redirect_en;
    assign post_cnt = (CW + 1)'(count) + (CW + 1)'(1) - (CW + 1)'(pop);
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        addr_d = addr_q;
        push = 1'b0;
        case (state_q)
            IDLE: state_d = !bus.redirect_en && bus.fetch_en && count < CW'(DEPTH) ? REQ : IDLE;
            REQ: begin
                if (bus.imem_ack) begin
                    push = !bus.redirect_en;
                    pc_d = pc_inc(pc_q);
                    state_d = push && bus.fetch_en && post_cnt < (CW + 1)'(DEPTH) ? REQ : IDLE;
                end else if (bus.redirect_en) begin
                    // request cannot be withdrawn: remember its address and wait for the ack
                    addr_d = pc_q;
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = bus.imem_ack ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
        if (bus.redirect_en) pc_d = bus.redirect_pc;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q <= RESET_PC;
            addr_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            addr_q <= addr_d;
        end
    end
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(bus.redirect_en),
        .wr_entry('{instr: bus.imem_rdata, pc: pc_q}),
        .count(count),
        .head(head)
    );
    assign bus.imem_req = state_q != IDLE;
    assign bus.imem_addr = state_q == DRAIN ? addr_q : pc_q;
    assign bus.instr_valid = count != '0;
    assign bus.instr_data = head.instr;
    assign bus.instr_pc = head.pc;
endmodule
